// File: rtl/idu_pkg.sv
// Shared definitions for the IDU issue stage.
//   - Width constants for registers, PC, register index and ALU opcode.
//   - ALU opcode encodings.
//   - Bit offsets of each field inside the packed dynamic instruction
//     (DYN_INST), so a wrapper can pack the iss_* outputs for EXEU.
package idu_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int PC_WIDTH       = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALUOP_WIDTH    = 4;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  // ALU opcode encodings.
  localparam logic [ALUOP_WIDTH-1:0] ADD_ALUOP = 4'h0;
  localparam logic [ALUOP_WIDTH-1:0] SUB_ALUOP = 4'h1;
  localparam logic [ALUOP_WIDTH-1:0] AND_ALUOP = 4'h2;
  localparam logic [ALUOP_WIDTH-1:0] OR_ALUOP  = 4'h3;
  localparam logic [ALUOP_WIDTH-1:0] XOR_ALUOP = 4'h4;
  localparam logic [ALUOP_WIDTH-1:0] SLL_ALUOP = 4'h5;
  localparam logic [ALUOP_WIDTH-1:0] SRL_ALUOP = 4'h6;
  localparam logic [ALUOP_WIDTH-1:0] SRA_ALUOP = 4'h7;
  localparam logic [ALUOP_WIDTH-1:0] SLT_ALUOP = 4'h8;

  // DYN_INST layout, LSB first:
  //   use_imm | use_rd | use_rs2 | use_rs1 | rs2_val | rs1_val | imm | rd | aluop | pc
  localparam int DYN_USE_IMM_OFF = 0;
  localparam int DYN_USE_RD_OFF  = 1;
  localparam int DYN_USE_RS2_OFF = 2;
  localparam int DYN_USE_RS1_OFF = 3;
  localparam int DYN_RS2_VAL_OFF = 4;
  localparam int DYN_RS1_VAL_OFF = DYN_RS2_VAL_OFF + DATA_WIDTH;
  localparam int DYN_IMM_OFF     = DYN_RS1_VAL_OFF + DATA_WIDTH;
  localparam int DYN_RD_OFF      = DYN_IMM_OFF + DATA_WIDTH;
  localparam int DYN_ALUOP_OFF   = DYN_RD_OFF + REG_ADDR_WIDTH;
  localparam int DYN_PC_OFF      = DYN_ALUOP_OFF + ALUOP_WIDTH;
  localparam int DYN_INST_WIDTH  = DYN_PC_OFF + PC_WIDTH;

endpackage

// File: rtl/idu_regfile.sv
// Integer register file for the issue stage.
//   - Two combinational read ports (rs1/rs2) with same-cycle bypass of the
//     write port, so a writeback is visible to the operand read at once.
//   - One write port driven by EXEU writeback.
//   - x0 reads as zero and ignores writes.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears all entries)
//   rs1_addr/rs2_addr       read indices
//   rs1_val/rs2_val         read data (bypassed)
//   wr_en/wr_addr/wr_val    write port
module idu_regfile
  import idu_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = REG_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_val,
  output logic [DW-1:0] rs2_val,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_val
);

  localparam int NREGS = 1 << AW;

  logic [DW-1:0] regs [NREGS];
  logic          wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  // NOTE: the array is reset because architectural state must read 0 after
  // reset; this keeps it in flops rather than a RAM macro, which is fine at
  // 32 entries.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_val;
    end
  end

  // NOTE: each output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_addr != '0) rs1_val = (wr_hit && wr_addr == rs1_addr) ? wr_val : regs[rs1_addr];
    if (rs2_addr != '0) rs2_val = (wr_hit && wr_addr == rs2_addr) ? wr_val : regs[rs2_addr];
  end

endmodule

// File: rtl/idu_issue.sv
// Issue stage at the IDU end of the IDU<->EXEU interface.
//   - Accepts decoded instructions (dec_*), reads operands from idu_regfile.
//   - Per-register busy scoreboard stalls RAW/WAW hazards.
//   - Registered valid/ready dynamic instruction toward EXEU (iss_*).
//   - Absorbs EXEU writeback (wb_*) into regfile and scoreboard, bypassed to
//     the same-cycle operand read and hazard check.
// Ports:
//   dec_*      decoded instruction in, dec_ready_o handshake out
//   iss_*      registered dynamic instruction out, iss_ready_i from EXEU
//   wb_*       writeback from EXEU
//   busy_o     scoreboard vector; wb_err_o sticky writeback-to-idle error
module idu_issue
  import idu_pkg::*;
#(
  parameter int DATA_WIDTH     = idu_pkg::DATA_WIDTH,
  parameter int PC_WIDTH       = idu_pkg::PC_WIDTH,
  parameter int REG_ADDR_WIDTH = idu_pkg::REG_ADDR_WIDTH,
  parameter int ALUOP_WIDTH    = idu_pkg::ALUOP_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dec_valid_i,
  output logic                         dec_ready_o,
  input  logic [PC_WIDTH-1:0]          dec_pc_i,
  input  logic [ALUOP_WIDTH-1:0]       dec_aluop_i,
  input  logic [REG_ADDR_WIDTH-1:0]    dec_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]    dec_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0]    dec_rd_i,
  input  logic                         dec_use_rs1_i,
  input  logic                         dec_use_rs2_i,
  input  logic                         dec_use_rd_i,
  input  logic                         dec_use_imm_i,
  input  logic [DATA_WIDTH-1:0]        dec_imm_i,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output logic [PC_WIDTH-1:0]          iss_pc_o,
  output logic [ALUOP_WIDTH-1:0]       iss_aluop_o,
  output logic [REG_ADDR_WIDTH-1:0]    iss_rd_o,
  output logic [DATA_WIDTH-1:0]        iss_imm_o,
  output logic [DATA_WIDTH-1:0]        iss_rs1_val_o,
  output logic [DATA_WIDTH-1:0]        iss_rs2_val_o,
  output logic                         iss_use_rs1_o,
  output logic                         iss_use_rs2_o,
  output logic                         iss_use_rd_o,
  output logic                         iss_use_imm_o,
  input  logic                         wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_rd_i,
  input  logic [DATA_WIDTH-1:0]        wb_val_i,
  output logic [(1<<REG_ADDR_WIDTH)-1:0] busy_o,
  output logic                         wb_err_o
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      wb_mask;
  logic [NREGS-1:0]      set_mask;
  logic [NREGS-1:0]      eff_busy;
  logic                  wb_hit;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  idu_regfile #(
    .DW (DATA_WIDTH),
    .AW (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (dec_rs1_i),
    .rs2_addr (dec_rs2_i),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .wr_en    (wb_en_i),
    .wr_addr  (wb_rd_i),
    .wr_val   (wb_val_i)
  );

  // Writes to x0 are dropped entirely, so x0 never enters the scoreboard.
  assign wb_hit   = wb_en_i && (wb_rd_i != '0);
  assign wb_mask  = wb_hit ? (ONE_HOT0 << wb_rd_i) : '0;
  // A register being written back this cycle no longer blocks issue.
  assign eff_busy = busy & ~wb_mask;

  assign hazard = (dec_use_rs1_i && eff_busy[dec_rs1_i]) ||
                  (dec_use_rs2_i && eff_busy[dec_rs2_i]) ||
                  (dec_use_rd_i && (dec_rd_i != '0) && eff_busy[dec_rd_i]);

  assign dec_ready_o = (!iss_valid_o || iss_ready_i) && !hazard;
  assign accept      = dec_valid_i && dec_ready_o;
  assign set_mask    = (accept && dec_use_rd_i && (dec_rd_i != '0)) ? (ONE_HOT0 << dec_rd_i) : '0;
  assign busy_o      = busy;

  // Scoreboard: clear on writeback, then set on accept, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      wb_err_o <= 1'b0;
    end else begin
      busy <= (busy & ~wb_mask) | set_mask;
      if (wb_hit && !busy[wb_rd_i]) wb_err_o <= 1'b1;
    end
  end

  // Issue register: load on accept, drop valid when consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_o   <= 1'b0;
      iss_pc_o      <= '0;
      iss_aluop_o   <= '0;
      iss_rd_o      <= '0;
      iss_imm_o     <= '0;
      iss_rs1_val_o <= '0;
      iss_rs2_val_o <= '0;
      iss_use_rs1_o <= 1'b0;
      iss_use_rs2_o <= 1'b0;
      iss_use_rd_o  <= 1'b0;
      iss_use_imm_o <= 1'b0;
    end else if (accept) begin
      iss_valid_o   <= 1'b1;
      iss_pc_o      <= dec_pc_i;
      iss_aluop_o   <= dec_aluop_i;
      iss_rd_o      <= dec_rd_i;
      iss_imm_o     <= dec_imm_i;
      iss_rs1_val_o <= dec_use_rs1_i ? rs1_val : '0;
      iss_rs2_val_o <= dec_use_rs2_i ? rs2_val : '0;
      iss_use_rs1_o <= dec_use_rs1_i;
      iss_use_rs2_o <= dec_use_rs2_i;
      iss_use_rd_o  <= dec_use_rd_i;
      iss_use_imm_o <= dec_use_imm_i;
    end else if (iss_valid_o && iss_ready_i) begin
      iss_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idu_issue.sv
// Directed self-checking bench for idu_issue.
module tb_idu_issue;
  import idu_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      dec_valid_i;
  logic                      dec_ready_o;
  logic [PC_WIDTH-1:0]       dec_pc_i;
  logic [ALUOP_WIDTH-1:0]    dec_aluop_i;
  logic [REG_ADDR_WIDTH-1:0] dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic                      dec_use_rs1_i, dec_use_rs2_i, dec_use_rd_i, dec_use_imm_i;
  logic [DATA_WIDTH-1:0]     dec_imm_i;
  logic                      iss_valid_o;
  logic                      iss_ready_i;
  logic [PC_WIDTH-1:0]       iss_pc_o;
  logic [ALUOP_WIDTH-1:0]    iss_aluop_o;
  logic [REG_ADDR_WIDTH-1:0] iss_rd_o;
  logic [DATA_WIDTH-1:0]     iss_imm_o, iss_rs1_val_o, iss_rs2_val_o;
  logic                      iss_use_rs1_o, iss_use_rs2_o, iss_use_rd_o, iss_use_imm_o;
  logic                      wb_en_i;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_i;
  logic [DATA_WIDTH-1:0]     wb_val_i;
  logic [NUM_REGS-1:0]       busy_o;
  logic                      wb_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  idu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_pc_i(dec_pc_i), .dec_aluop_i(dec_aluop_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
    .dec_use_rd_i(dec_use_rd_i), .dec_use_imm_i(dec_use_imm_i),
    .dec_imm_i(dec_imm_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_pc_o(iss_pc_o), .iss_aluop_o(iss_aluop_o), .iss_rd_o(iss_rd_o),
    .iss_imm_o(iss_imm_o), .iss_rs1_val_o(iss_rs1_val_o), .iss_rs2_val_o(iss_rs2_val_o),
    .iss_use_rs1_o(iss_use_rs1_o), .iss_use_rs2_o(iss_use_rs2_o),
    .iss_use_rd_o(iss_use_rd_o), .iss_use_imm_o(iss_use_imm_o),
    .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_val_i(wb_val_i),
    .busy_o(busy_o), .wb_err_o(wb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PC_WIDTH-1:0] pc, input logic [3:0] aluop,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic ud, input logic ui,
                       input logic [DATA_WIDTH-1:0] imm);
    dec_valid_i = 1'b1; dec_pc_i = pc; dec_aluop_i = aluop;
    dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
    dec_use_rs1_i = u1; dec_use_rs2_i = u2; dec_use_rd_i = ud; dec_use_imm_i = ui;
    dec_imm_i = imm;
  endtask

  task automatic wb_cycle(input logic [4:0] rd, input logic [DATA_WIDTH-1:0] val);
    wb_en_i = 1'b1; wb_rd_i = rd; wb_val_i = val;
    step();
    wb_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dec_valid_i = 0; dec_pc_i = '0; dec_aluop_i = '0; dec_rs1_i = '0; dec_rs2_i = '0;
    dec_rd_i = '0; dec_use_rs1_i = 0; dec_use_rs2_i = 0; dec_use_rd_i = 0; dec_use_imm_i = 0;
    dec_imm_i = '0; iss_ready_i = 1'b1; wb_en_i = 0; wb_rd_i = '0; wb_val_i = '0;
    #12;
    n_cmp++; if (iss_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", iss_valid_o); end
    n_cmp++; if (busy_o !== '0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy_o); end
    n_cmp++; if (wb_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_wb_err: got %b want 0", wb_err_o); end
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", dec_ready_o); end
    n_cmp++; if (iss_pc_o !== '0 || iss_rs1_val_o !== '0) begin n_bad++; $display("FAIL reset_fields: pc %h rs1 %h want 0", iss_pc_o, iss_rs1_val_o); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_addi();
    drive(64'h100, ADD_ALUOP, 5'd0, 5'd0, 5'd1, 1, 0, 1, 1, 64'd5);
    #1;
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL addi_ready: got %b want 1", dec_ready_o); end
    step();
    dec_valid_i = 0;
    n_cmp++; if (iss_valid_o !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %b want 1", iss_valid_o); end
    n_cmp++; if (iss_rs1_val_o !== 64'd0) begin n_bad++; $display("FAIL addi_rs1: got %h want 0", iss_rs1_val_o); end
    n_cmp++; if (iss_imm_o !== 64'd5) begin n_bad++; $display("FAIL addi_imm: got %h want 5", iss_imm_o); end
    n_cmp++; if (iss_pc_o !== 64'h100 || iss_rd_o !== 5'd1) begin n_bad++; $display("FAIL addi_pc_rd: pc %h rd %0d want 100/1", iss_pc_o, iss_rd_o); end
    n_cmp++; if ({iss_use_rs1_o, iss_use_rs2_o, iss_use_rd_o, iss_use_imm_o} !== 4'b1011) begin n_bad++;
      $display("FAIL addi_flags: got %b want 1011", {iss_use_rs1_o, iss_use_rs2_o, iss_use_rd_o, iss_use_imm_o}); end
    n_cmp++; if (busy_o !== 32'h0000_0002) begin n_bad++; $display("FAIL addi_busy: got %h want 00000002", busy_o); end
    step();
    n_cmp++; if (iss_valid_o !== 1'b0) begin n_bad++; $display("FAIL addi_drain: got %b want 0", iss_valid_o); end
  endtask

  task automatic test_raw();
    drive(64'h104, ADD_ALUOP, 5'd1, 5'd1, 5'd2, 1, 1, 1, 0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (dec_ready_o !== 1'b0 || iss_valid_o !== 1'b0) begin n_bad++;
        $display("FAIL raw_stall%0d: ready %b valid %b want 0/0", i, dec_ready_o, iss_valid_o); end
      step();
    end
    wb_en_i = 1; wb_rd_i = 5'd1; wb_val_i = 64'd5;
    #1;
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL raw_release: got %b want 1", dec_ready_o); end
    step();
    wb_en_i = 0; dec_valid_i = 0;
    n_cmp++; if (iss_valid_o !== 1'b1 || iss_rs1_val_o !== 64'd5 || iss_rs2_val_o !== 64'd5) begin n_bad++;
      $display("FAIL raw_bypass: valid %b rs1 %h rs2 %h want 1/5/5", iss_valid_o, iss_rs1_val_o, iss_rs2_val_o); end
    n_cmp++; if (busy_o !== 32'h0000_0004) begin n_bad++; $display("FAIL raw_busy: got %h want 00000004", busy_o); end
    n_cmp++; if (wb_err_o !== 1'b0) begin n_bad++; $display("FAIL raw_wb_err: got %b want 0", wb_err_o); end
    step();
    wb_cycle(5'd2, 64'd9);
  endtask

  // Three hazard-free instructions on consecutive cycles; x1 = 5 from test_raw.
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(64'h400 + 64'(4 * i), SUB_ALUOP, 5'd1, 5'd1, 5'd0, 1, 0, 0, 0, 64'(i));
      #1;
      n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, dec_ready_o); end
      step();
      n_cmp++; if (iss_valid_o !== 1'b1 || iss_pc_o !== 64'h400 + 64'(4 * i)) begin n_bad++;
        $display("FAIL b2b_pc%0d: valid %b pc %h want 1/%h", i, iss_valid_o, iss_pc_o, 64'h400 + 64'(4 * i)); end
      n_cmp++; if (iss_rs1_val_o !== 64'd5 || iss_rs2_val_o !== 64'd0) begin n_bad++;
        $display("FAIL b2b_ops%0d: rs1 %h rs2 %h want 5/0", i, iss_rs1_val_o, iss_rs2_val_o); end
    end
    dec_valid_i = 0;
    step();
  endtask

  task automatic test_backpressure();
    iss_ready_i = 0;
    drive(64'h200, OR_ALUOP, 5'd0, 5'd0, 5'd4, 0, 0, 1, 0, 64'd0);
    step();
    drive(64'h204, AND_ALUOP, 5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (dec_ready_o !== 1'b0 || iss_valid_o !== 1'b1 || iss_pc_o !== 64'h200 || iss_rd_o !== 5'd4) begin n_bad++;
        $display("FAIL bp_hold%0d: ready %b valid %b pc %h rd %0d want 0/1/200/4", i, dec_ready_o, iss_valid_o, iss_pc_o, iss_rd_o); end
      step();
    end
    iss_ready_i = 1;
    #1;
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", dec_ready_o); end
    step();
    dec_valid_i = 0;
    n_cmp++; if (iss_valid_o !== 1'b1 || iss_pc_o !== 64'h204 || iss_rd_o !== 5'd5) begin n_bad++;
      $display("FAIL bp_second: valid %b pc %h rd %0d want 1/204/5", iss_valid_o, iss_pc_o, iss_rd_o); end
    step();
    n_cmp++; if (iss_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b want 0", iss_valid_o); end
    n_cmp++; if (busy_o !== 32'h0000_0030) begin n_bad++; $display("FAIL bp_busy: got %h want 00000030", busy_o); end
    wb_cycle(5'd4, 64'd4);
    wb_cycle(5'd5, 64'd5);
  endtask

  task automatic test_set_clear();
    drive(64'h300, ADD_ALUOP, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 64'd0);
    step();
    dec_valid_i = 0;
    step();
    wb_en_i = 1; wb_rd_i = 5'd3; wb_val_i = 64'h33;
    drive(64'h304, ADD_ALUOP, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 64'd0);
    #1;
    n_cmp++; if (dec_ready_o !== 1'b1) begin n_bad++; $display("FAIL sc_ready: got %b want 1", dec_ready_o); end
    step();
    wb_en_i = 0; dec_valid_i = 0;
    n_cmp++; if (busy_o !== 32'h0000_0008) begin n_bad++; $display("FAIL sc_busy: got %h want 00000008", busy_o); end
    n_cmp++; if (iss_rs1_val_o !== 64'h33) begin n_bad++; $display("FAIL sc_bypass: got %h want 33", iss_rs1_val_o); end
    n_cmp++; if (dut.u_regfile.regs[3] !== 64'h33) begin n_bad++; $display("FAIL sc_x3: got %h want 33", dut.u_regfile.regs[3]); end
    n_cmp++; if (wb_err_o !== 1'b0) begin n_bad++; $display("FAIL sc_wb_err: got %b want 0", wb_err_o); end
    step();
    wb_cycle(5'd3, 64'h44);
  endtask

  task automatic test_x0_err();
    wb_cycle(5'd0, 64'hDEAD);
    n_cmp++; if (wb_err_o !== 1'b0 || busy_o !== '0) begin n_bad++;
      $display("FAIL x0_wb: err %b busy %h want 0/0", wb_err_o, busy_o); end
    drive(64'h500, ADD_ALUOP, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 64'd0);
    step();
    dec_valid_i = 0;
    n_cmp++; if (iss_rs1_val_o !== 64'd0 || iss_rs2_val_o !== 64'd0) begin n_bad++;
      $display("FAIL x0_read: rs1 %h rs2 %h want 0/0", iss_rs1_val_o, iss_rs2_val_o); end
    wb_cycle(5'd7, 64'h77);
    n_cmp++; if (wb_err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", wb_err_o); end
    step(); step();
    n_cmp++; if (wb_err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", wb_err_o); end
  endtask

  task automatic test_async_reset();
    iss_ready_i = 0;
    drive(64'h600, ADD_ALUOP, 5'd0, 5'd0, 5'd1, 0, 0, 1, 0, 64'd0);
    step();
    dec_valid_i = 0;
    n_cmp++; if (iss_valid_o !== 1'b1 || busy_o[1] !== 1'b1) begin n_bad++;
      $display("FAIL ar_pre: valid %b busy1 %b want 1/1", iss_valid_o, busy_o[1]); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (iss_valid_o !== 1'b0 || busy_o !== '0 || wb_err_o !== 1'b0) begin n_bad++;
      $display("FAIL ar_clear: valid %b busy %h err %b want 0/0/0", iss_valid_o, busy_o, wb_err_o); end
    n_cmp++; if (dut.u_regfile.regs[1] !== 64'd0) begin n_bad++; $display("FAIL ar_x1: got %h want 0", dut.u_regfile.regs[1]); end
    #2 rst_n = 1;
    iss_ready_i = 1;
    step();
    drive(64'h700, ADD_ALUOP, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 64'd0);
    step();
    dec_valid_i = 0;
    n_cmp++; if (iss_valid_o !== 1'b1 || iss_rs1_val_o !== 64'd0) begin n_bad++;
      $display("FAIL ar_read_x1: valid %b rs1 %h want 1/0", iss_valid_o, iss_rs1_val_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_set_clear();
    test_x0_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
